// File: rtl/sdram_wr_burst_if.sv
// ---------------------------------------------------------------------------
// sdram_wr_burst_if
//
// Purpose: bundles the job handshake, arbiter handshake, FIFO side and SDRAM
// command/address/data signals of the SDRAM burst write engine.
//
// Signals:
//   wr_trig        job start pulse (sampled only while the engine is idle)
//   wr_start_addr  {bank,row,col} start address, col BL-aligned
//   wr_len         number of bursts in the job (0 = ignored)
//   wr_busy        engine is not idle
//   wr_done        one-cycle job completion pulse
//   wr_req         bus request to the arbiter
//   wr_en          bus grant from the arbiter
//   ref_req        refresh request
//   flag_wr_end    one-cycle pulse releasing the bus to the arbiter
//   din            show-ahead FIFO head data
//   din_rd         FIFO pop, one per data beat
//   wr_cmd         {cs_n,ras_n,cas_n,we_n}
//   wr_addr        SDRAM address bus
//   bank_addr      SDRAM bank select
//   wr_data        SDRAM write data
//
// Modports:
//   master  the write engine
//   slave   the surrounding system (arbiter, FIFO, job source, SDRAM mux)
// ---------------------------------------------------------------------------
interface sdram_wr_burst_if #(
    parameter int DW     = 16,
    parameter int ROW_W  = 12,
    parameter int COL_W  = 9,
    parameter int BANK_W = 2,
    parameter int LEN_W  = 16
);
    logic                          wr_trig;
    logic [BANK_W+ROW_W+COL_W-1:0] wr_start_addr;
    logic [LEN_W-1:0]              wr_len;
    logic                          wr_busy;
    logic                          wr_done;
    logic                          wr_req;
    logic                          wr_en;
    logic                          ref_req;
    logic                          flag_wr_end;
    logic [DW-1:0]                 din;
    logic                          din_rd;
    logic [3:0]                    wr_cmd;
    logic [ROW_W-1:0]              wr_addr;
    logic [BANK_W-1:0]             bank_addr;
    logic [DW-1:0]                 wr_data;

    modport master (
        input  wr_trig, wr_start_addr, wr_len, wr_en, ref_req, din,
        output wr_busy, wr_done, wr_req, flag_wr_end, din_rd,
               wr_cmd, wr_addr, bank_addr, wr_data
    );

    modport slave (
        output wr_trig, wr_start_addr, wr_len, wr_en, ref_req, din,
        input  wr_busy, wr_done, wr_req, flag_wr_end, din_rd,
               wr_cmd, wr_addr, bank_addr, wr_data
    );
endinterface

// File: rtl/sdram_wr_burst.sv
// ---------------------------------------------------------------------------
// sdram_wr_burst
//
// Purpose: SDRAM burst write engine. Takes a {bank,row,col} start address and
// a burst count, streams data out of a show-ahead FIFO, walks across column,
// row and bank boundaries on its own, and hands the bus back to the arbiter
// whenever a refresh is pending, resuming at the same position afterwards.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    sdram_wr_burst_if.master (job, arbiter, FIFO and SDRAM signals)
//
// Timing notes:
//   wr_cmd, wr_addr, bank_addr and din_rd decode the registered state and
//   phase counter, so they only change after clock edges. wr_req, wr_busy,
//   wr_done and flag_wr_end are registered directly.
// ---------------------------------------------------------------------------
module sdram_wr_burst #(
    parameter int DW     = 16,
    parameter int ROW_W  = 12,
    parameter int COL_W  = 9,
    parameter int BANK_W = 2,
    parameter int BL     = 4,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sdram_wr_burst_if.master  bus
);

    // SDRAM commands {cs_n,ras_n,cas_n,we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    // One phase counter serves ACT wait, burst beats and PRE wait.
    localparam int PH_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int PH_MAX   = (PH_MAX_A > BL) ? PH_MAX_A : BL;
    localparam int PH_W     = $clog2(PH_MAX) + 1;

    localparam logic [PH_W-1:0] PH_RCD_LAST = PH_W'(T_RCD - 1);
    localparam logic [PH_W-1:0] PH_RP_LAST  = PH_W'(T_RP - 1);
    localparam logic [PH_W-1:0] PH_BL_LAST  = PH_W'(BL - 1);

    // PRE with A10 high closes all banks at once.
    localparam logic [ROW_W-1:0] PRE_ALL_ADDR = ROW_W'(1) << 10;

    localparam int AW = BANK_W + ROW_W + COL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACT,
        S_WRITE,
        S_PRE
    } state_t;

    state_t             r_state;
    logic [PH_W-1:0]    r_phase;
    logic [BANK_W-1:0]  r_bank;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [LEN_W-1:0]   r_rem;
    logic               r_ref_pend;
    logic               r_wr_req;
    logic               r_wr_busy;
    logic               r_wr_done;
    logic               r_flag_wr_end;

    logic [COL_W-1:0]   w_col_next;
    logic               w_col_wrap;
    logic [ROW_W-1:0]   w_row_next;
    logic               w_row_wrap;
    logic [LEN_W-1:0]   w_rem_next;
    logic [BANK_W-1:0]  w_start_bank;
    logic [ROW_W-1:0]   w_start_row;
    logic [COL_W-1:0]   w_start_col;

    logic [3:0]         w_cmd;
    logic [ROW_W-1:0]   w_addr;
    logic [BANK_W-1:0]  w_bank;
    logic               w_din_rd;

    // Start address fields {bank,row,col}
    assign w_start_bank = bus.wr_start_addr[AW-1 -: BANK_W];
    assign w_start_row  = bus.wr_start_addr[COL_W +: ROW_W];
    assign w_start_col  = bus.wr_start_addr[COL_W-1:0];

    // Pointer advance at the end of a burst. The column is BL-aligned, so
    // the sum lands exactly on zero when the row is exhausted.
    assign w_col_next = r_col + COL_W'(BL);
    assign w_col_wrap = (w_col_next == '0);
    assign w_row_next = r_row + ROW_W'(1);
    assign w_row_wrap = (w_row_next == '0);
    assign w_rem_next = r_rem - LEN_W'(1);

    // -----------------------------------------------------------------------
    // Command / address decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_cmd    = CMD_NOP;
        w_addr   = '0;
        w_bank   = '0;
        w_din_rd = 1'b0;
        case (r_state)
            S_ACT: begin
                if (r_phase == '0) begin
                    w_cmd  = CMD_ACT;
                    w_addr = r_row;
                    w_bank = r_bank;
                end
            end
            S_WRITE: begin
                w_din_rd = 1'b1;
                if (r_phase == '0) begin
                    w_cmd  = CMD_WR;
                    // Column on the low bits; A10 stays 0 (no auto-precharge)
                    w_addr = {{(ROW_W-COL_W){1'b0}}, r_col};
                    w_bank = r_bank;
                end
            end
            S_PRE: begin
                if (r_phase == '0) begin
                    w_cmd  = CMD_PRE;
                    w_addr = PRE_ALL_ADDR;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.wr_cmd      = w_cmd;
    assign bus.wr_addr     = w_addr;
    assign bus.bank_addr   = w_bank;
    assign bus.din_rd      = w_din_rd;
    assign bus.wr_data     = bus.din;
    assign bus.wr_req      = r_wr_req;
    assign bus.wr_busy     = r_wr_busy;
    assign bus.wr_done     = r_wr_done;
    assign bus.flag_wr_end = r_flag_wr_end;

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_phase       <= '0;
            r_bank        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_rem         <= '0;
            r_ref_pend    <= 1'b0;
            r_wr_req      <= 1'b0;
            r_wr_busy     <= 1'b0;
            r_wr_done     <= 1'b0;
            r_flag_wr_end <= 1'b0;
        end else begin
            r_wr_done     <= 1'b0;
            r_flag_wr_end <= 1'b0;

            // While we own the bus, remember refresh requests so the engine
            // can yield at the next burst boundary. In IDLE/REQ the arbiter
            // already sees the request itself.
            if (bus.ref_req && (r_state == S_ACT || r_state == S_WRITE ||
                                r_state == S_PRE)) begin
                r_ref_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.wr_trig && (bus.wr_len != '0)) begin
                        r_bank    <= w_start_bank;
                        r_row     <= w_start_row;
                        r_col     <= w_start_col;
                        r_rem     <= bus.wr_len;
                        r_wr_req  <= 1'b1;
                        r_wr_busy <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (bus.wr_en) begin
                        r_wr_req <= 1'b0;
                        r_phase  <= '0;
                        r_state  <= S_ACT;
                    end
                end

                S_ACT: begin
                    if (r_phase == PH_RCD_LAST) begin
                        r_phase <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end

                S_WRITE: begin
                    if (r_phase == PH_BL_LAST) begin
                        r_phase <= '0;
                        r_rem   <= w_rem_next;
                        r_col   <= w_col_next;
                        if (w_col_wrap) begin
                            r_row <= w_row_next;
                            if (w_row_wrap) begin
                                r_bank <= r_bank + BANK_W'(1);
                            end
                        end
                        // Done, row change and refresh yield all close the
                        // row through the same PRE; the exit decides where
                        // to go next. Otherwise the next WR follows with no
                        // gap.
                        if ((w_rem_next == '0) || w_col_wrap || r_ref_pend) begin
                            r_state <= S_PRE;
                        end
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end

                S_PRE: begin
                    if (r_phase == PH_RP_LAST) begin
                        r_phase    <= '0;
                        r_ref_pend <= 1'b0;
                        if (r_rem == '0) begin
                            r_wr_done     <= 1'b1;
                            r_flag_wr_end <= 1'b1;
                            r_wr_busy     <= 1'b0;
                            r_state       <= S_IDLE;
                        end else if (r_ref_pend) begin
                            // Give the bus away, then ask for it again; the
                            // pointers already hold the resume position.
                            r_flag_wr_end <= 1'b1;
                            r_wr_req      <= 1'b1;
                            r_state       <= S_REQ;
                        end else begin
                            // Pure row change: keep the bus.
                            r_state <= S_ACT;
                        end
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wr_burst.sv
// ---------------------------------------------------------------------------
// tb_sdram_wr_burst
//
// Scoreboard bench for sdram_wr_burst. Stimulus pushes the expected command
// events (with cycle offsets from the trigger) and idle-state snapshots into
// queues; the monitor pops and compares whenever the DUT shows a command,
// wr_done or flag_wr_end, and whenever a snapshot is queued.
// ---------------------------------------------------------------------------
module tb_sdram_wr_burst;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_wr_burst_if #(.DW(16), .ROW_W(12), .COL_W(9), .BANK_W(2), .LEN_W(16)) bus ();

    sdram_wr_burst #(
        .DW(16), .ROW_W(12), .COL_W(9), .BANK_W(2),
        .BL(4), .T_RCD(2), .T_RP(2), .LEN_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Show-ahead FIFO model: head word advances after each pop.
    logic [15:0] rd_idx = 16'd0;
    always @(posedge clk) if (bus.din_rd) rd_idx <= rd_idx + 16'd1;
    assign bus.din = 16'hA5C3 ^ (rd_idx * 16'd7);

    typedef struct packed {
        logic [15:0] off;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic        done;
        logic        flag;
    } ev_t;

    typedef struct packed {
        logic        busy;
        logic        req;
        logic        done;
        logic        flag;
        logic        rd;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic [15:0] n_din;
        logic [15:0] n_req;
    } snap_t;

    ev_t   exp_q[$];
    snap_t snap_q[$];
    string name_q[$];

    int t0       = 0;
    int n_vec    = 0;
    int n_err    = 0;
    int n_din    = 0;
    int n_req    = 0;
    int n_tmo    = 0;
    int tmo_seen = 0;
    int exp_din  = 0;
    int exp_req  = 0;

    function automatic void ev(int off, logic [3:0] cmd, int addr, int bank,
                               logic done, logic flag);
        ev_t e;
        e.off  = 16'(off);
        e.cmd  = cmd;
        e.addr = 12'(addr);
        e.bank = 2'(bank);
        e.done = done;
        e.flag = flag;
        exp_q.push_back(e);
    endfunction

    function automatic void snap_idle(string nm);
        snap_t s;
        s.busy  = 1'b0;
        s.req   = 1'b0;
        s.done  = 1'b0;
        s.flag  = 1'b0;
        s.rd    = 1'b0;
        s.cmd   = NOP;
        s.addr  = 12'd0;
        s.bank  = 2'd0;
        s.n_din = 16'(exp_din);
        s.n_req = 16'(exp_req);
        snap_q.push_back(s);
        name_q.push_back(nm);
    endfunction

    // ---------------------------------------------------------------- monitor
    ev_t   got_e, need_e;
    snap_t got_s, need_s;
    string snap_nm;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.din_rd) begin
                n_din++;
                n_vec++;
                if (bus.wr_data !== bus.din) begin
                    n_err++;
                    $display("FAIL wr_data cyc %0d: got %h need %h", cyc, bus.wr_data, bus.din);
                end
            end
            if (bus.wr_req) n_req++;
            if (bus.wr_cmd != NOP || bus.wr_done || bus.flag_wr_end) begin
                got_e.off  = 16'(cyc - t0);
                got_e.cmd  = bus.wr_cmd;
                got_e.addr = bus.wr_addr;
                got_e.bank = bus.bank_addr;
                got_e.done = bus.wr_done;
                got_e.flag = bus.flag_wr_end;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got off=%0d cmd=%b addr=%h bank=%0d done=%b flag=%b, need none",
                             got_e.off, got_e.cmd, got_e.addr, got_e.bank, got_e.done, got_e.flag);
                end else begin
                    need_e = exp_q.pop_front();
                    if (got_e !== need_e) begin
                        n_err++;
                        $display("FAIL event: got off=%0d cmd=%b addr=%h bank=%0d done=%b flag=%b, need off=%0d cmd=%b addr=%h bank=%0d done=%b flag=%b",
                                 got_e.off, got_e.cmd, got_e.addr, got_e.bank, got_e.done, got_e.flag,
                                 need_e.off, need_e.cmd, need_e.addr, need_e.bank, need_e.done, need_e.flag);
                    end else begin
                        $display("event ok: off=%0d cmd=%b addr=%h bank=%0d done=%b flag=%b",
                                 got_e.off, got_e.cmd, got_e.addr, got_e.bank, got_e.done, got_e.flag);
                    end
                end
            end
        end
        if (snap_q.size() != 0) begin
            need_s  = snap_q.pop_front();
            snap_nm = name_q.pop_front();
            got_s.busy  = bus.wr_busy;
            got_s.req   = bus.wr_req;
            got_s.done  = bus.wr_done;
            got_s.flag  = bus.flag_wr_end;
            got_s.rd    = bus.din_rd;
            got_s.cmd   = bus.wr_cmd;
            got_s.addr  = bus.wr_addr;
            got_s.bank  = bus.bank_addr;
            got_s.n_din = 16'(n_din);
            got_s.n_req = 16'(n_req);
            n_vec++;
            if (got_s !== need_s) begin
                n_err++;
                $display("FAIL snap_%s: got busy=%b req=%b done=%b flag=%b rd=%b cmd=%b addr=%h bank=%0d din_rd_total=%0d req_total=%0d, need busy=%b req=%b done=%b flag=%b rd=%b cmd=%b addr=%h bank=%0d din_rd_total=%0d req_total=%0d",
                         snap_nm, got_s.busy, got_s.req, got_s.done, got_s.flag, got_s.rd, got_s.cmd,
                         got_s.addr, got_s.bank, got_s.n_din, got_s.n_req,
                         need_s.busy, need_s.req, need_s.done, need_s.flag, need_s.rd, need_s.cmd,
                         need_s.addr, need_s.bank, need_s.n_din, need_s.n_req);
            end else begin
                $display("snap %s ok: din_rd_total=%0d req_total=%0d", snap_nm, got_s.n_din, got_s.n_req);
            end
        end
        if (n_tmo != tmo_seen) begin
            tmo_seen = n_tmo;
            n_vec++;
            n_err++;
            $display("FAIL job_timeout: got pending events after 400 cycles, need all events seen");
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(int bank, int row, int col, int len);
        tick();
        t0 = cyc;
        bus.wr_trig       = 1'b1;
        bus.wr_start_addr = {2'(bank), 12'(row), 9'(col)};
        bus.wr_len        = 16'(len);
        tick();
        bus.wr_trig = 1'b0;
    endtask

    task automatic wait_to(int off);
        while (cyc - t0 < off) tick();
    endtask

    task automatic finish_job(string nm, int din_add, int req_add);
        int k;
        exp_din += din_add;
        exp_req += req_add;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_tmo++;
            exp_q.delete();
        end
        snap_idle(nm);
        tick();
        tick();
    endtask

    task automatic single_events(int row);
        ev(2,  ACT, row,   0, 1'b0, 1'b0);
        ev(4,  WR,  0,     0, 1'b0, 1'b0);
        ev(8,  PRE, 'h400, 0, 1'b0, 1'b0);
        ev(10, NOP, 0,     0, 1'b1, 1'b1);
    endtask

    initial begin
        bus.wr_trig       = 1'b0;
        bus.wr_start_addr = '0;
        bus.wr_len        = '0;
        bus.wr_en         = 1'b1;
        bus.ref_req       = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        snap_idle("reset");
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Single burst
        single_events(5);
        start_job(0, 5, 0, 1);
        finish_job("single", 4, 1);

        // Back-to-back bursts in one row
        ev(2,  ACT, 5,     0, 1'b0, 1'b0);
        ev(4,  WR,  8,     0, 1'b0, 1'b0);
        ev(8,  WR,  12,    0, 1'b0, 1'b0);
        ev(12, WR,  16,    0, 1'b0, 1'b0);
        ev(16, PRE, 'h400, 0, 1'b0, 1'b0);
        ev(18, NOP, 0,     0, 1'b1, 1'b1);
        start_job(0, 5, 8, 3);
        finish_job("back2back", 12, 1);

        // Row crossing keeps the bus
        ev(2,  ACT, 5,     0, 1'b0, 1'b0);
        ev(4,  WR,  508,   0, 1'b0, 1'b0);
        ev(8,  PRE, 'h400, 0, 1'b0, 1'b0);
        ev(10, ACT, 6,     0, 1'b0, 1'b0);
        ev(12, WR,  0,     0, 1'b0, 1'b0);
        ev(16, PRE, 'h400, 0, 1'b0, 1'b0);
        ev(18, NOP, 0,     0, 1'b1, 1'b1);
        start_job(0, 5, 508, 2);
        finish_job("row_cross", 8, 1);

        // Row 4095 wraps to row 0 of the next bank
        ev(2,  ACT, 4095,  1, 1'b0, 1'b0);
        ev(4,  WR,  508,   1, 1'b0, 1'b0);
        ev(8,  PRE, 'h400, 0, 1'b0, 1'b0);
        ev(10, ACT, 0,     2, 1'b0, 1'b0);
        ev(12, WR,  0,     2, 1'b0, 1'b0);
        ev(16, PRE, 'h400, 0, 1'b0, 1'b0);
        ev(18, NOP, 0,     0, 1'b1, 1'b1);
        start_job(1, 4095, 508, 2);
        finish_job("bank_wrap", 8, 1);

        // Refresh preemption during burst 2, re-grant delayed
        ev(2,  ACT, 7,     0, 1'b0, 1'b0);
        ev(4,  WR,  0,     0, 1'b0, 1'b0);
        ev(8,  WR,  4,     0, 1'b0, 1'b0);
        ev(12, PRE, 'h400, 0, 1'b0, 1'b0);
        ev(14, NOP, 0,     0, 1'b0, 1'b1);
        ev(18, ACT, 7,     0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ev(20 + 4*i, WR, 8 + 4*i, 0, 1'b0, 1'b0);
        ev(52, PRE, 'h400, 0, 1'b0, 1'b0);
        ev(54, NOP, 0,     0, 1'b1, 1'b1);
        start_job(0, 7, 0, 10);
        wait_to(5);
        bus.wr_en = 1'b0;
        wait_to(9);
        bus.ref_req = 1'b1;
        wait_to(10);
        bus.ref_req = 1'b0;
        wait_to(17);
        bus.wr_en = 1'b1;
        finish_job("refresh", 40, 5);

        // Reset mid-WRITE aborts at once
        ev(2, ACT, 5, 0, 1'b0, 1'b0);
        ev(4, WR,  0, 0, 1'b0, 1'b0);
        start_job(0, 5, 0, 5);
        wait_to(5);
        rst_n = 1'b0;
        #1;
        exp_din += 1;
        exp_req += 1;
        snap_idle("abort");
        tick();
        rst_n = 1'b1;
        tick();

        // Normal job after the abort
        single_events(9);
        start_job(0, 9, 0, 1);
        finish_job("after_abort", 4, 1);

        // Zero length trigger is ignored
        start_job(0, 3, 0, 0);
        wait_to(6);
        finish_job("len0", 0, 0);

        // Trigger while busy is ignored
        single_events(2);
        start_job(0, 2, 0, 1);
        wait_to(5);
        bus.wr_trig       = 1'b1;
        bus.wr_start_addr = {2'd3, 12'd100, 9'd64};
        bus.wr_len        = 16'd7;
        tick();
        bus.wr_trig = 1'b0;
        finish_job("busy_trig", 4, 1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000ns, need finish");
        $fatal(1, "watchdog");
    end

endmodule
